// File: rtl/dsp_alu_arbiter.sv
// dsp_alu_arbiter
// Round-robin front end that shares one pipelined DSP ALU among four requesters.
// A requester is granted combinationally. Its operands are registered into the DSP
// issue port, and a tag pipeline of latency+1 stages carries the requester id and
// the reserved-opcode flag down to the response stage. There the DSP result is
// captured and steered back to the requester that issued it.
module dsp_alu_arbiter #(
    parameter int width   = 32,
    parameter int latency = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            req_valid,
    output logic [3:0]            req_ready,
    input  logic [7:0]            req_op,
    input  logic [4*width-1:0]    req_a,
    input  logic [4*width-1:0]    req_b,
    output logic                  dsp_valid,
    output logic [1:0]            dsp_op,
    output logic [width-1:0]      dsp_a,
    output logic [width-1:0]      dsp_b,
    input  logic [width-1:0]      dsp_y,
    output logic [3:0]            rsp_valid,
    output logic [width-1:0]      rsp_y,
    output logic                  rsp_err,
    output logic [2:0]            inflight
);

    typedef struct packed {
        logic       valid;
        logic [1:0] id;
        logic       err;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, id: 2'd0, err: 1'b0};

    logic [1:0]       ptr_r;
    tag_t             tag_r [0:latency];

    logic             found_s;
    logic [1:0]       gidx_s;
    logic [1:0]       cand_s;
    logic             transfer_s;
    logic [1:0]       sel_op_s;
    logic [width-1:0] sel_a_s;
    logic [width-1:0] sel_b_s;
    logic             err_s;
    logic [1:0]       issue_op_s;
    logic             resp_s;

    // Round-robin search: first valid requester starting at ptr_r, wrapping mod 4.
    always_comb begin
        found_s = 1'b0;
        gidx_s  = 2'd0;
        cand_s  = 2'd0;
        for (int off = 0; off < 4; off++) begin
            cand_s = ptr_r + 2'(off);
            if (!found_s && req_valid[cand_s]) begin
                found_s = 1'b1;
                gidx_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant is one-hot on the winner and suppressed while reset is asserted.
    always_comb begin
        transfer_s = found_s & ~reset;
        if (transfer_s) begin
            req_ready = 4'b0001 << gidx_s;
        end else begin
            req_ready = 4'b0000;
        end
    end

    // Select the winning requester's opcode and operands.
    always_comb begin
        case (gidx_s)
            2'd0: begin
                sel_op_s = req_op[1:0];
                sel_a_s  = req_a[0*width +: width];
                sel_b_s  = req_b[0*width +: width];
            end
            2'd1: begin
                sel_op_s = req_op[3:2];
                sel_a_s  = req_a[1*width +: width];
                sel_b_s  = req_b[1*width +: width];
            end
            2'd2: begin
                sel_op_s = req_op[5:4];
                sel_a_s  = req_a[2*width +: width];
                sel_b_s  = req_b[2*width +: width];
            end
            2'd3: begin
                sel_op_s = req_op[7:6];
                sel_a_s  = req_a[3*width +: width];
                sel_b_s  = req_b[3*width +: width];
            end
            default: begin
                sel_op_s = 2'b00;
                sel_a_s  = {width{1'b0}};
                sel_b_s  = {width{1'b0}};
            end
        endcase
    end

    // The reserved opcode is flagged and replaced by a harmless add toward the DSP.
    always_comb begin
        err_s      = (sel_op_s == 2'b11);
        issue_op_s = err_s ? 2'b00 : sel_op_s;
        resp_s     = tag_r[latency].valid;
    end

    // Issue register and round-robin pointer; operands hold between issues.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_r     <= 2'd0;
            dsp_valid <= 1'b0;
            dsp_op    <= 2'b00;
            dsp_a     <= {width{1'b0}};
            dsp_b     <= {width{1'b0}};
        end else if (transfer_s) begin
            ptr_r     <= gidx_s + 2'd1;
            dsp_valid <= 1'b1;
            dsp_op    <= issue_op_s;
            dsp_a     <= sel_a_s;
            dsp_b     <= sel_b_s;
        end else begin
            dsp_valid <= 1'b0;
        end
    end

    // Tag pipeline tracking each issue until its DSP result is due.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j <= latency; j++) begin
                tag_r[j] <= TAG_IDLE;
            end
        end else begin
            tag_r[0] <= '{valid: transfer_s, id: gidx_s, err: transfer_s & err_s};
            for (int j = 1; j <= latency; j++) begin
                tag_r[j] <= tag_r[j-1];
            end
        end
    end

    // Response register: capture the DSP result and steer it to the owning requester.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= 4'b0000;
            rsp_y     <= {width{1'b0}};
            rsp_err   <= 1'b0;
        end else if (resp_s) begin
            rsp_valid <= 4'b0001 << tag_r[latency].id;
            rsp_y     <= tag_r[latency].err ? {width{1'b0}} : dsp_y;
            rsp_err   <= tag_r[latency].err;
        end else begin
            rsp_valid <= 4'b0000;
            rsp_err   <= 1'b0;
        end
    end

    // Outstanding-request counter: up on accept, down on response, hold on both/neither.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= 3'd0;
        end else begin
            case ({transfer_s, resp_s})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
